// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and default line/beat widths.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } arb_state_t;

    localparam int DEFAULT_LINE_W = 256;
    localparam int DEFAULT_BEAT_W = 64;

endpackage

// File: rtl/mem_arbiter_grant.sv
// Combinational channel selection for mem_arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin from the last grant; otherwise fixed priority (lowest index).
module arb_grant #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0]  ptr,
`endif
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    int   cand;
    logic found;

`ifdef ARB_ROUND_ROBIN_EN
    // Search starts one past the previous winner and wraps around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = 0;
        found     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (int'(ptr) + 1 + i) % NUM_CH;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end
`else
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = 0;
        found     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = i;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NUM_CH cache clients onto one burst-based physical memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module mem_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_CH = 2,
    parameter int LINE_W = DEFAULT_LINE_W,
    parameter int BEAT_W = DEFAULT_BEAT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*32-1:0]     ch_addr,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [31:0]              pmem_address,
    output logic [BEAT_W-1:0]        pmem_wdata,
    input  logic [BEAT_W-1:0]        pmem_rdata,
    input  logic                     pmem_resp
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);

    arb_state_t        state, state_next;
    logic [CNT_W-1:0]  beat_cnt;
    logic              is_write;
    logic [NUM_CH-1:0] grant_q;
    logic [31:0]       addr_q;
    logic [LINE_W-1:0] wline_q;
    logic [LINE_W-1:0] buffer;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              take;
    logic              last_beat;

    assign req       = ch_read | ch_write;
    assign take      = (state == IDLE) && (|req);
    assign last_beat = pmem_resp && (beat_cnt == CNT_W'(BEATS - 1));

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_grant;

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= IDX_W'(NUM_CH - 1);
        else if (take)
            last_grant <= grant_idx;
    end

    arb_grant #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_grant (
        .req       (req),
        .ptr       (last_grant),
        .grant     (grant),
        .grant_idx (grant_idx)
    );
`else
    arb_grant #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_grant (
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req) state_next = BURST;
            BURST:   if (last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The granted client's request is snapshotted so later input changes cannot disturb the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            is_write <= 1'b0;
            grant_q  <= '0;
            addr_q   <= '0;
            wline_q  <= '0;
            buffer   <= '0;
        end else if (take) begin
            beat_cnt <= '0;
            grant_q  <= grant;
            is_write <= ch_write[grant_idx];
            addr_q   <= ch_addr[grant_idx*32 +: 32] & LINE_MASK;
            wline_q  <= ch_wdata[grant_idx*LINE_W +: LINE_W];
        end else if (state == BURST && pmem_resp) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (!is_write)
                buffer[beat_cnt*BEAT_W +: BEAT_W] <= pmem_rdata;
        end
    end

    assign pmem_read    = (state == BURST) && !is_write;
    assign pmem_write   = (state == BURST) && is_write;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wline_q[beat_cnt*BEAT_W +: BEAT_W];
    assign ch_rdata     = buffer;
    assign ch_resp      = (state == DONE) ? grant_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (NUM_CH=2, LINE_W=256, BEAT_W=64).
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   ch_read;
    logic [1:0]   ch_write;
    logic [63:0]  ch_addr;
    logic [511:0] ch_wdata;
    logic [255:0] ch_rdata;
    logic [1:0]   ch_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    int total = 0;
    int bad   = 0;

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .ch_read      (ch_read),
        .ch_write     (ch_write),
        .ch_addr      (ch_addr),
        .ch_wdata     (ch_wdata),
        .ch_rdata     (ch_rdata),
        .ch_resp      (ch_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] rd, input logic [1:0] wr);
        ch_read  = rd;
        ch_write = wr;
    endtask

    // Called one cycle after the grant edge; returns in the DONE cycle.
    task automatic serveBurst(input logic [255:0] rline, input int gap, input logic wr,
                              input logic [255:0] wline, input logic [31:0] exp_addr,
                              input logic [1:0] exp_resp);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                checkOutput("gap_read", 256'(pmem_read), 256'(!wr));
                checkOutput("gap_addr", 256'(pmem_address), 256'(exp_addr));
                step();
            end
            checkOutput("burst_read", 256'(pmem_read), 256'(!wr));
            checkOutput("burst_write", 256'(pmem_write), 256'(wr));
            checkOutput("burst_addr", 256'(pmem_address), 256'(exp_addr));
            checkOutput("burst_noresp", 256'(ch_resp), 256'(0));
            if (wr)
                checkOutput("wdata_beat", 256'(pmem_wdata), 256'(wline[k*64 +: 64]));
            pmem_resp  = 1'b1;
            pmem_rdata = rline[k*64 +: 64];
            step();
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
        end
        checkOutput("done_resp", 256'(ch_resp), 256'(exp_resp));
        checkOutput("done_read_low", 256'(pmem_read), 256'(0));
        checkOutput("done_write_low", 256'(pmem_write), 256'(0));
        if (!wr)
            checkOutput("done_rdata", ch_rdata, rline);
    endtask

    logic [255:0] rline_a;
    logic [255:0] rline_b;
    logic [255:0] wline_a;
    logic [1:0]   exp_grant;
    logic [31:0]  exp_addr;

    initial begin
        rline_a = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
        rline_b = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                   64'h5A5A_5A5A_A5A5_A5A5, 64'hDEAD_BEEF_CAFE_F00D};
        wline_a = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};

        rst        = 1'b1;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        ch_addr    = '0;
        ch_wdata   = '0;
        applyStimulus(2'b00, 2'b00);
        step();
        step();
        checkOutput("rst_read", 256'(pmem_read), 256'(0));
        checkOutput("rst_write", 256'(pmem_write), 256'(0));
        checkOutput("rst_resp", 256'(ch_resp), 256'(0));
        checkOutput("rst_addr", 256'(pmem_address), 256'(0));
        checkOutput("rst_rdata", ch_rdata, 256'(0));
        rst = 1'b0;
        step();

        $display("[TB] single read on channel 0");
        ch_addr[31:0] = 32'h0000_1234;
        applyStimulus(2'b01, 2'b00);
        step();
        serveBurst(rline_a, 0, 1'b0, 256'(0), 32'h0000_1220, 2'b01);
        applyStimulus(2'b00, 2'b00);
        step();
        checkOutput("read_resp_once", 256'(ch_resp), 256'(0));

        $display("[TB] single write on channel 1, inputs disturbed after grant");
        ch_addr[63:32]    = 32'h0000_8010;
        ch_wdata[511:256] = wline_a;
        applyStimulus(2'b00, 2'b10);
        step();
        ch_addr[63:32]    = 32'hFFFF_FFFF;
        ch_wdata[511:256] = '1;
        serveBurst(256'(0), 0, 1'b1, wline_a, 32'h0000_8000, 2'b10);
        applyStimulus(2'b00, 2'b00);
        step();
        checkOutput("write_resp_once", 256'(ch_resp), 256'(0));

        $display("[TB] both channels reading, held");
        ch_addr = {32'h0000_2040, 32'h0000_0100};
        applyStimulus(2'b11, 2'b00);
        for (int n = 0; n < 4; n++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_grant = (n % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_grant = 2'b01;
`endif
            exp_addr = (exp_grant == 2'b01) ? 32'h0000_0100 : 32'h0000_2040;
            step();
            serveBurst(rline_b, 0, 1'b0, 256'(0), exp_addr, exp_grant);
            if (n == 3)
                applyStimulus(2'b00, 2'b00);
            step();
            checkOutput("contend_idle_resp", 256'(ch_resp), 256'(0));
        end

        $display("[TB] read with gaps between beats");
        ch_addr[63:32] = 32'h0000_3FFF;
        applyStimulus(2'b10, 2'b00);
        step();
        serveBurst(rline_a, 3, 1'b0, 256'(0), 32'h0000_3FE0, 2'b10);
        applyStimulus(2'b00, 2'b00);
        step();

        $display("[TB] reset after second beat");
        ch_addr[31:0] = 32'h0000_5000;
        applyStimulus(2'b01, 2'b00);
        step();
        for (int k = 0; k < 2; k++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = rline_b[k*64 +: 64];
            step();
        end
        pmem_resp = 1'b0;
        checkOutput("pre_rst_read", 256'(pmem_read), 256'(1));
        rst = 1'b1;
        applyStimulus(2'b00, 2'b00);
        step();
        checkOutput("abort_read_low", 256'(pmem_read), 256'(0));
        checkOutput("abort_noresp", 256'(ch_resp), 256'(0));
        rst = 1'b0;
        step();
        checkOutput("abort_noresp2", 256'(ch_resp), 256'(0));
        checkOutput("abort_addr_clear", 256'(pmem_address), 256'(0));
        checkOutput("abort_buf_clear", ch_rdata, 256'(0));

        $display("[TB] spurious pmem_resp while idle");
        for (int k = 0; k < 3; k++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            step();
            checkOutput("spur_read", 256'(pmem_read), 256'(0));
            checkOutput("spur_write", 256'(pmem_write), 256'(0));
            checkOutput("spur_resp", 256'(ch_resp), 256'(0));
            checkOutput("spur_buf", ch_rdata, 256'(0));
        end
        pmem_resp  = 1'b0;
        pmem_rdata = '0;

        $display("[TB] fresh read after abort");
        ch_addr[31:0] = 32'h0000_1234;
        applyStimulus(2'b01, 2'b00);
        step();
        serveBurst(rline_b, 1, 1'b0, 256'(0), 32'h0000_1220, 2'b01);
        applyStimulus(2'b00, 2'b00);
        step();
        checkOutput("fresh_resp_once", 256'(ch_resp), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of cache clients (2..8).
REQ-002 Parameter LINE_W, default 256, cache line width in bits.
REQ-003 Parameter BEAT_W, default 64, physical memory beat width; BEATS = LINE_W/BEAT_W, a power of two.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ch_read  input  NUM_CH  per-client line read request, held until ch_resp.
REQ-007 ch_write  input  NUM_CH  per-client line write request, held until ch_resp.
REQ-008 ch_addr  input  NUM_CH x 32  per-client byte address.
REQ-009 ch_wdata  input  NUM_CH x LINE_W  per-client write line.
REQ-010 ch_rdata  output  LINE_W  read line, shared by all clients, valid when ch_resp is high.
REQ-011 ch_resp  output  NUM_CH  one-hot completion pulse.
REQ-012 pmem_read, pmem_write  output  1 each  physical memory burst request.
REQ-013 pmem_address  output  32  line-aligned burst address.
REQ-014 pmem_wdata  output  BEAT_W  current write beat.
REQ-015 pmem_rdata  input  BEAT_W  current read beat.
REQ-016 pmem_resp  input  1  one pulse per beat accepted or returned.

Function
REQ-017 FSM states SHALL be IDLE, BURST, DONE.
REQ-018 IDLE: if any ch_read|ch_write is high, grant one channel, latch its address (low log2(LINE_W/8) bits zeroed), direction, and wdata, clear beat_cnt, and go to BURST; otherwise stay in IDLE.
REQ-019 A channel asserting both ch_read and ch_write SHALL be served as a write.
REQ-020 BURST: hold pmem_read or pmem_write high with a stable pmem_address; pmem_wdata = latched line beat[beat_cnt], beat 0 in the LSBs.
REQ-021 Each pmem_resp in BURST SHALL increment beat_cnt; on a read it SHALL store pmem_rdata into buffer beat[beat_cnt].
REQ-022 pmem_resp on beat BEATS-1 SHALL move the FSM to DONE; pmem_read/pmem_write go low the cycle after.
REQ-023 DONE: ch_resp[grant] high for exactly one cycle, ch_rdata = buffer, then IDLE unconditionally.
REQ-024 Latency: a request sampled in IDLE at cycle 0 asserts pmem_* at cycle 1; ch_resp fires one cycle after the last pmem_resp.
REQ-025 Clients SHALL drop their request the cycle after ch_resp; a request still high in IDLE is a new transaction.
REQ-026 pmem_resp outside BURST SHALL be ignored.
REQ-027 Changes to a client's inputs after grant SHALL NOT affect the burst in flight.
REQ-028 Only one burst SHALL be outstanding at a time.

Reset
REQ-029 On rst: state IDLE, beat_cnt 0, pmem_read 0, pmem_write 0, ch_resp all 0, pmem_address 0, buffer 0, round-robin pointer NUM_CH-1.
REQ-030 rst during BURST SHALL abort the burst; pmem_read/pmem_write are low from the next cycle, and no ch_resp is issued.

Configuration
REQ-031 Macro ARB_ROUND_ROBIN_EN defined: grant the first requester at or above (last_grant+1) mod NUM_CH; last_grant updates on each grant.
REQ-032 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; no pointer register exists.

Structure
REQ-033 Shared package rv32i_types SHALL hold the arb_state_t enum (IDLE, BURST, DONE) and the default LINE_W and BEAT_W constants.
REQ-034 Sub-module arb_grant SHALL hold the combinational grant selection (requests and pointer in, one-hot grant and index out); all sequential logic stays in mem_arbiter.

Verification
REQ-035 Single read: ch_read[0]=1, addr 0x0000_1234; pmem returns beats 0x11..,0x22..,0x33..,0x44.. -> pmem_address 0x0000_1220, ch_rdata = {0x44..,0x33..,0x22..,0x11..}, ch_resp=2'b01 for one cycle.
REQ-036 Single write: ch_write[1]=1, wdata with beats A,B,C,D -> pmem_wdata A,B,C,D in order across four pmem_resp, then ch_resp=2'b10.
REQ-037 Contention: ch_read=2'b11 held -> with ARB_ROUND_ROBIN_EN, grants alternate 0,1,0,1; without it, channel 0 is always granted first.
REQ-038 pmem_resp with 3-cycle gaps between beats -> pmem_read stays high throughout and the address stays stable.
REQ-039 rst asserted after the 2nd beat -> pmem_read is low the next cycle, no ch_resp, and a fresh request then completes normally.
REQ-040 Spurious pmem_resp in IDLE -> no state change and no ch_resp.
